select_my_action: RTL and testbench

- Action-selection engine for the node's routing/aggregation learner.
- On a start request it chooses an action using an epsilon-greedy rule: compare a random input against a threshold, then pick either the learned next hop or the next-sink candidate.
- It flags whether the packet is held for aggregation and writes a two-word result record into the shared 16-bit-word data memory (2048 x 8-bit, byte-addressed).
- Sits between the RNG/route-table logic and the memory module; its only memory traffic is writes.

---
 rtl/select_my_action.sv | 126 ++++++++++++
 tb/tb_select_my_action.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/select_my_action.sv
// rtl/select_my_action.sv - epsilon-greedy action selection with a two-word result record write
module select_my_action #(
  parameter int                    WORD_WIDTH  = 16,
  parameter logic [WORD_WIDTH-1:0] EPSILON     = 16'd10,
  parameter logic [WORD_WIDTH-1:0] RESULT_ADDR = 16'h0100
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  start,
  output logic [WORD_WIDTH-1:0] address,
  output logic                  wr_en,
  input  logic [WORD_WIDTH-1:0] nexthop,
  input  logic [WORD_WIDTH-1:0] nextsinks,
  input  logic [WORD_WIDTH-1:0] rng_in,
  output logic [WORD_WIDTH-1:0] action,
  output logic [WORD_WIDTH-1:0] mem_data_in,
  output logic                  forAggregation,
  output logic                  done
);

  localparam logic [WORD_WIDTH-1:0] AGG_ADDR = RESULT_ADDR + WORD_WIDTH'(2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALC   = 3'd1,
    WR_ACT = 3'd2,
    WR_AGG = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [WORD_WIDTH-1:0] nexthop_q, nextsinks_q, rng_q;
  logic                  latch_en;

  logic [WORD_WIDTH-1:0] address_nx, action_nx, data_nx;
  logic                  wr_en_nx, agg_nx, done_nx;

  always_ff @(posedge clock) begin
    if (nrst) begin
      state          <= IDLE;
      nexthop_q      <= '0;
      nextsinks_q    <= '0;
      rng_q          <= '0;
      address        <= '0;
      wr_en          <= 1'b0;
      action         <= '0;
      mem_data_in    <= '0;
      forAggregation <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_nx;
      address        <= address_nx;
      wr_en          <= wr_en_nx;
      action         <= action_nx;
      mem_data_in    <= data_nx;
      forAggregation <= agg_nx;
      done           <= done_nx;
      // Operands are frozen at the start request so the run is immune to later input changes.
      if (latch_en) begin
        nexthop_q   <= nexthop;
        nextsinks_q <= nextsinks;
        rng_q       <= rng_in;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    latch_en   = 1'b0;
    address_nx = '0;
    wr_en_nx   = 1'b0;
    data_nx    = '0;
    done_nx    = 1'b0;
    action_nx  = action;
    agg_nx     = forAggregation;

    case (state)
      IDLE: begin
        if (start) begin
          latch_en = 1'b1;
          state_nx = CALC;
        end
      end

      CALC: begin
        if (rng_q < EPSILON) begin
          action_nx = nextsinks_q;
          agg_nx    = 1'b0;
        end else begin
          action_nx = nexthop_q;
          agg_nx    = 1'b1;
        end
        state_nx = WR_ACT;
      end

      WR_ACT: begin
        wr_en_nx   = 1'b1;
        address_nx = RESULT_ADDR;
        data_nx    = action;
        state_nx   = WR_AGG;
      end

      WR_AGG: begin
        wr_en_nx   = 1'b1;
        address_nx = AGG_ADDR;
        data_nx    = {{(WORD_WIDTH-1){1'b0}}, forAggregation};
        state_nx   = DONE;
      end

      DONE: begin
        // done is always shown for at least one cycle, then follows start until it drops.
        if (!done || start) begin
          done_nx = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_select_my_action.sv
// tb/tb_select_my_action.sv - directed self-checking bench for select_my_action
module tb_select_my_action;

  logic        clock = 1'b0;
  logic        nrst;
  logic        start;
  logic [15:0] address;
  logic        wr_en;
  logic [15:0] nexthop;
  logic [15:0] nextsinks;
  logic [15:0] rng_in;
  logic [15:0] action;
  logic [15:0] mem_data_in;
  logic        forAggregation;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  logic [15:0] mem [int];

  select_my_action dut (
    .clock          (clock),
    .nrst           (nrst),
    .start          (start),
    .address        (address),
    .wr_en          (wr_en),
    .nexthop        (nexthop),
    .nextsinks      (nextsinks),
    .rng_in         (rng_in),
    .action         (action),
    .mem_data_in    (mem_data_in),
    .forAggregation (forAggregation),
    .done           (done)
  );

  always #5 clock = ~clock;

  // Memory model: commits the write presented before each rising edge.
  always @(posedge clock) begin
    if (wr_en) begin
      wr_cnt = wr_cnt + 1;
      mem[int'(address)] = mem_data_in;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic start_run(input logic [15:0] nh, input logic [15:0] ns, input logic [15:0] rng);
    nexthop   = nh;
    nextsinks = ns;
    rng_in    = rng;
    start     = 1'b1;
    tick(5);
  endtask

  task automatic end_run();
    start = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    nrst = 1'b1; start = 1'b1;
    nexthop = 16'd1; nextsinks = 16'd2; rng_in = 16'd3;
    tick(3);
    n_checks++;
    if ({address, wr_en, action, mem_data_in, forAggregation, done} !== 51'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%h wr=%b act=%h data=%h agg=%b done=%b, required all 0",
               address, wr_en, action, mem_data_in, forAggregation, done);
    end
    start = 1'b0;
    nrst  = 1'b0;
    tick(2);
    n_checks++;
    if (wr_cnt !== 0) begin
      n_fail++;
      $display("FAIL reset_no_writes: got %0d writes, required 0", wr_cnt);
    end
  endtask

  task automatic test_explore();
    int w0 = wr_cnt;
    nexthop = 16'd65; nextsinks = 16'd65; rng_in = 16'd5; start = 1'b1;
    tick(2);
    n_checks++;
    if (action !== 16'd65 || forAggregation !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL explore_calc: got act=%0d agg=%b done=%b wr=%b, required 65 0 0 0",
               action, forAggregation, done, wr_en);
    end
    tick(1);
    n_checks++;
    if (wr_en !== 1'b1 || address !== 16'h0100 || mem_data_in !== 16'd65) begin
      n_fail++;
      $display("FAIL explore_wr_act: got wr=%b addr=%h data=%0d, required 1 0100 65",
               wr_en, address, mem_data_in);
    end
    tick(1);
    n_checks++;
    if (wr_en !== 1'b1 || address !== 16'h0102 || mem_data_in !== 16'd0) begin
      n_fail++;
      $display("FAIL explore_wr_agg: got wr=%b addr=%h data=%0d, required 1 0102 0",
               wr_en, address, mem_data_in);
    end
    tick(1);
    n_checks++;
    if (done !== 1'b1 || wr_en !== 1'b0 || address !== 16'h0 || mem_data_in !== 16'h0) begin
      n_fail++;
      $display("FAIL explore_done: got done=%b wr=%b addr=%h data=%h, required 1 0 0000 0000",
               done, wr_en, address, mem_data_in);
    end
    tick(3);
    n_checks++;
    if (done !== 1'b1 || wr_cnt - w0 !== 2 || mem[32'h100] !== 16'd65 || mem[32'h102] !== 16'd0) begin
      n_fail++;
      $display("FAIL explore_hold: got done=%b writes=%0d m100=%0d m102=%0d, required 1 2 65 0",
               done, wr_cnt - w0, mem[32'h100], mem[32'h102]);
    end
    start = 1'b0;
    tick(1);
    n_checks++;
    if (done !== 1'b0 || action !== 16'd65) begin
      n_fail++;
      $display("FAIL explore_release: got done=%b act=%0d, required 0 65", done, action);
    end
    tick(1);
  endtask

  task automatic test_exploit();
    int w0 = wr_cnt;
    start_run(16'd12, 16'd40, 16'd200);
    n_checks++;
    if (action !== 16'd12 || forAggregation !== 1'b1 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL exploit_result: got act=%0d agg=%b done=%b, required 12 1 1",
               action, forAggregation, done);
    end
    n_checks++;
    if (mem[32'h100] !== 16'd12 || mem[32'h102] !== 16'd1 || wr_cnt - w0 !== 2) begin
      n_fail++;
      $display("FAIL exploit_mem: got m100=%0d m102=%0d writes=%0d, required 12 1 2",
               mem[32'h100], mem[32'h102], wr_cnt - w0);
    end
    end_run();
  endtask

  task automatic test_boundary();
    start_run(16'd21, 16'd34, 16'd10);
    n_checks++;
    if (action !== 16'd21 || forAggregation !== 1'b1 || mem[32'h102] !== 16'd1) begin
      n_fail++;
      $display("FAIL boundary_eq: got act=%0d agg=%b m102=%0d, required 21 1 1",
               action, forAggregation, mem[32'h102]);
    end
    end_run();
    start_run(16'd21, 16'd34, 16'd9);
    n_checks++;
    if (action !== 16'd34 || forAggregation !== 1'b0 || mem[32'h100] !== 16'd34 || mem[32'h102] !== 16'd0) begin
      n_fail++;
      $display("FAIL boundary_below: got act=%0d agg=%b m100=%0d m102=%0d, required 34 0 34 0",
               action, forAggregation, mem[32'h100], mem[32'h102]);
    end
    end_run();
  endtask

  task automatic test_retrigger();
    int w0 = wr_cnt;
    start_run(16'd300, 16'd400, 16'd50);
    tick(6);
    n_checks++;
    if (wr_cnt - w0 !== 2 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL retrigger_hold: got writes=%0d done=%b, required 2 1", wr_cnt - w0, done);
    end
    start = 1'b0;
    tick(1);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL retrigger_clear: got done=%b, required 0", done);
    end
    tick(1);
    w0 = wr_cnt;
    start_run(16'd300, 16'd400, 16'd2);
    tick(2);
    n_checks++;
    if (wr_cnt - w0 !== 2 || done !== 1'b1 || action !== 16'd400 || mem[32'h100] !== 16'd400) begin
      n_fail++;
      $display("FAIL retrigger_second: got writes=%0d done=%b act=%0d m100=%0d, required 2 1 400 400",
               wr_cnt - w0, done, action, mem[32'h100]);
    end
    end_run();
  endtask

  task automatic test_input_stability();
    nexthop = 16'd7; nextsinks = 16'd8; rng_in = 16'd100; start = 1'b1;
    tick(1);
    nexthop = 16'd99; rng_in = 16'd0;
    tick(4);
    n_checks++;
    if (action !== 16'd7 || forAggregation !== 1'b1 || mem[32'h100] !== 16'd7 || mem[32'h102] !== 16'd1) begin
      n_fail++;
      $display("FAIL stability: got act=%0d agg=%b m100=%0d m102=%0d, required 7 1 7 1",
               action, forAggregation, mem[32'h100], mem[32'h102]);
    end
    end_run();
  endtask

  task automatic test_reset_mid_run();
    int w0 = wr_cnt;
    mem[32'h102] = 16'hdead;
    nexthop = 16'd3; nextsinks = 16'd4; rng_in = 16'd200; start = 1'b1;
    tick(3);
    n_checks++;
    if (wr_en !== 1'b1 || address !== 16'h0100) begin
      n_fail++;
      $display("FAIL midrst_pre: got wr=%b addr=%h, required 1 0100", wr_en, address);
    end
    nrst = 1'b1;
    tick(1);
    n_checks++;
    if (wr_en !== 1'b0 || done !== 1'b0 || action !== 16'd0 || address !== 16'd0 || forAggregation !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_abort: got wr=%b done=%b act=%0d addr=%h agg=%b, required 0 0 0 0000 0",
               wr_en, done, action, address, forAggregation);
    end
    nrst  = 1'b0;
    start = 1'b0;
    tick(5);
    n_checks++;
    if (mem[32'h102] !== 16'hdead || wr_cnt - w0 !== 1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_no_agg_write: got m102=%h writes=%0d done=%b, required dead 1 0",
               mem[32'h102], wr_cnt - w0, done);
    end
  endtask

  initial begin
    nrst = 1'b1; start = 1'b0;
    nexthop = '0; nextsinks = '0; rng_in = '0;
    test_reset();
    test_explore();
    test_exploit();
    test_boundary();
    test_retrigger();
    test_input_stability();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
